// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared constants for the instruction-memory loader
package imem_loader_pkg;
    localparam int WORD = 16;
    localparam logic [7:0] SYNC_LOAD_DEF = 8'hA5;
    localparam logic [7:0] SYNC_GO_DEF   = 8'h5A;
    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_CHK  = 2'd1;
    localparam logic [1:0] ERR_TMO  = 2'd2;
    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_ADDR_HI = 4'd1;
    localparam logic [3:0] S_ADDR_LO = 4'd2;
    localparam logic [3:0] S_CNT_HI  = 4'd3;
    localparam logic [3:0] S_CNT_LO  = 4'd4;
    localparam logic [3:0] S_DATA_HI = 4'd5;
    localparam logic [3:0] S_DATA_LO = 4'd6;
    localparam logic [3:0] S_CHK     = 4'd7;
    localparam logic [3:0] S_RESP    = 4'd8;
endpackage

// File: rtl/imem_loader_timeout.sv
// ldr_timeout: idle-cycle counter that flags expiry after TIMEOUT quiet cycles
module ldr_timeout #(
    parameter int TIMEOUT = 1024
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);
    localparam int W = $clog2(TIMEOUT + 1);
    logic [W-1:0] r_cnt;
    // count enabled quiet cycles; any clear restarts from zero
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_cnt <= '0;
        else if (i_clr) r_cnt <= '0;
        else if (i_en) r_cnt <= r_cnt + 1'b1;
    end
    assign o_expire = i_en & ~i_clr & (r_cnt == W'(TIMEOUT - 1));
endmodule

// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader writing 16-bit words into instruction memory
module imem_loader import imem_loader_pkg::*; #(
    parameter int         TIMEOUT   = 1024,
    parameter logic [7:0] SYNC_LOAD = SYNC_LOAD_DEF,
    parameter logic [7:0] SYNC_GO   = SYNC_GO_DEF
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [7:0]      i_in_data,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    output logic            o_wr_en,
    output logic [WORD-1:0] o_wr_addr,
    output logic [WORD-1:0] o_wr_data,
    output logic            o_cpu_hold,
    output logic            o_done,
    output logic            o_err,
    output logic [1:0]      o_err_code,
    output logic [WORD-1:0] o_words_loaded
);
    logic [3:0]      r_state;
    logic [WORD-1:0] r_addr;
    logic [WORD-1:0] r_cnt;
    logic [7:0]      r_hi;
    logic [7:0]      r_chk;
    logic            r_wr_en;
    logic [WORD-1:0] r_wr_addr;
    logic [WORD-1:0] r_wr_data;
    logic            r_hold;
    logic            r_done;
    logic            r_err;
    logic [1:0]      r_err_code;
    logic [WORD-1:0] r_words;
    logic            w_acc;
    logic            w_busy;
    logic            w_expire;
    logic            w_sync_load;

    assign o_in_ready  = (r_state != S_RESP);
    assign w_acc       = i_in_valid & o_in_ready;
    assign w_busy      = (r_state != S_IDLE) & (r_state != S_RESP);
    assign w_sync_load = w_acc & (r_state == S_IDLE) & (i_in_data == SYNC_LOAD);

    ldr_timeout #(.TIMEOUT(TIMEOUT)) u_tmo (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clr    (w_acc | ~w_busy),
        .i_en     (w_busy),
        .o_expire (w_expire)
    );

    // frame parser: header, word payload with running XOR, checksum and response
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_cnt      <= '0;
            r_hi       <= '0;
            r_chk      <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_hold     <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
            r_words    <= '0;
        end else begin
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            if (w_expire) begin
                r_state    <= S_IDLE;
                r_err      <= 1'b1;
                r_err_code <= ERR_TMO;
            end else if (w_acc) begin
                case (r_state)
                    S_IDLE: begin
                        if (i_in_data == SYNC_LOAD) begin
                            r_state    <= S_ADDR_HI;
                            r_chk      <= '0;
                            r_words    <= '0;
                            r_err_code <= ERR_NONE;
                            r_hold     <= 1'b1;
                        end else if (i_in_data == SYNC_GO) begin
                            r_hold <= 1'b0;
                        end
                    end
                    S_ADDR_HI: begin
                        r_addr[15:8] <= i_in_data;
                        r_state      <= S_ADDR_LO;
                    end
                    S_ADDR_LO: begin
                        r_addr[7:0] <= i_in_data;
                        r_state     <= S_CNT_HI;
                    end
                    S_CNT_HI: begin
                        r_cnt[15:8] <= i_in_data;
                        r_state     <= S_CNT_LO;
                    end
                    S_CNT_LO: begin
                        r_cnt[7:0] <= i_in_data;
                        r_state    <= ({r_cnt[15:8], i_in_data} == '0) ? S_CHK : S_DATA_HI;
                    end
                    S_DATA_HI: begin
                        r_hi    <= i_in_data;
                        r_chk   <= r_chk ^ i_in_data;
                        r_state <= S_DATA_LO;
                    end
                    S_DATA_LO: begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_addr;
                        r_wr_data <= {r_hi, i_in_data};
                        r_addr    <= r_addr + 1'b1;
                        r_words   <= r_words + 1'b1;
                        r_cnt     <= r_cnt - 1'b1;
                        r_chk     <= r_chk ^ i_in_data;
                        r_state   <= (r_cnt == 16'd1) ? S_CHK : S_DATA_HI;
                    end
                    S_CHK: begin
                        r_done  <= (i_in_data == r_chk);
                        r_err   <= (i_in_data != r_chk);
                        if (i_in_data != r_chk) r_err_code <= ERR_CHK;
                        r_state <= S_RESP;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end else if (r_state == S_RESP) begin
                r_state <= S_IDLE;
            end
        end
    end

    assign o_wr_en        = r_wr_en;
    assign o_wr_addr      = r_wr_addr;
    assign o_wr_data      = r_wr_data;
    assign o_cpu_hold     = r_hold | w_sync_load;
    assign o_done         = r_done;
    assign o_err          = r_err;
    assign o_err_code     = r_err_code;
    assign o_words_loaded = r_words;
endmodule
